// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared widths, limits and FSM state type for the Gray receive decoder
package gray_pkg;
  localparam int GRAY_W  = 4;
  localparam int MOVES_W = 8;
  localparam logic [MOVES_W-1:0] MOVES_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_ERROR
  } state_t;
endpackage

// File: rtl/gray_rx_decoder_gtob.sv
// rtl/gray_rx_decoder_gtob.sv - combinational Gray-to-binary decode (module gtob)
module gtob
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] g,
  output logic [GRAY_W-1:0] b
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b = g;
    for (int i = 1; i < GRAY_W; i++) begin
      b = b ^ (g >> i);
    end
  end

endmodule

// File: rtl/gray_rx_decoder.sv
// rtl/gray_rx_decoder.sv - Gray-code receive decoder/tracker; GRAY_RX_SYNC_EN adds a 2-flop input synchroniser
module gray_rx_decoder
  import gray_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               G0,
  input  logic               G1,
  input  logic               G2,
  input  logic               G3,
  input  logic               clr_err,
  output logic               B0,
  output logic               B1,
  output logic               B2,
  output logic               B3,
  output logic               valid,
  output logic               dir,
  output logic               step,
  output logic               wrap,
  output logic               step_err,
  output logic [MOVES_W-1:0] moves
);

  logic [GRAY_W-1:0] g_in;
  logic [GRAY_W-1:0] samp;
  logic [GRAY_W-1:0] dec;
  logic              samp_vld;

  assign g_in = {G3, G2, G1, G0};

  // fill_q marks when the sample stage holds a real post-reset sample,
  // so IDLE never loads the reset contents of the sampling flops.
`ifdef GRAY_RX_SYNC_EN
  logic [GRAY_W-1:0] sync1_q;
  logic [GRAY_W-1:0] sync2_q;
  logic [1:0]        fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= g_in;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  assign samp     = sync2_q;
  assign samp_vld = fill_q[1];
`else
  logic [GRAY_W-1:0] samp_q;
  logic              fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
      fill_q <= 1'b0;
    end else begin
      samp_q <= g_in;
      fill_q <= 1'b1;
    end
  end

  assign samp     = samp_q;
  assign samp_vld = fill_q;
`endif

  gtob u_gtob (
    .g (samp),
    .b (dec)
  );

  state_t               state_q, state_nxt;
  logic [GRAY_W-1:0]    b_q, b_nxt;
  logic [GRAY_W-1:0]    b_inc, b_dec;
  logic                 valid_q, valid_nxt;
  logic                 dir_q, dir_nxt;
  logic                 step_q, step_nxt;
  logic                 wrap_q, wrap_nxt;
  logic                 err_q, err_nxt;
  logic [MOVES_W-1:0]   moves_q, moves_nxt;

  assign b_inc = b_q + GRAY_W'(1);
  assign b_dec = b_q - GRAY_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      valid_q <= 1'b0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      moves_q <= '0;
    end else begin
      state_q <= state_nxt;
      b_q     <= b_nxt;
      valid_q <= valid_nxt;
      dir_q   <= dir_nxt;
      step_q  <= step_nxt;
      wrap_q  <= wrap_nxt;
      err_q   <= err_nxt;
      moves_q <= moves_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    b_nxt     = b_q;
    valid_nxt = valid_q;
    dir_nxt   = dir_q;
    step_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    err_nxt   = err_q;
    moves_nxt = moves_q;

    // clr_err takes priority over whatever the tracker sees this cycle.
    if (clr_err) begin
      state_nxt = ST_IDLE;
      err_nxt   = 1'b0;
      valid_nxt = 1'b0;
      moves_nxt = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (samp_vld) begin
            b_nxt     = dec;
            valid_nxt = 1'b1;
            moves_nxt = '0;
            state_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (dec == b_inc) begin
            b_nxt    = dec;
            dir_nxt  = 1'b1;
            step_nxt = 1'b1;
            wrap_nxt = (b_q == '1);
            if (moves_q != MOVES_MAX) moves_nxt = moves_q + MOVES_W'(1);
          end else if (dec == b_dec) begin
            b_nxt    = dec;
            dir_nxt  = 1'b0;
            step_nxt = 1'b1;
            wrap_nxt = (b_q == '0);
            if (moves_q != MOVES_MAX) moves_nxt = moves_q + MOVES_W'(1);
          end else if (dec != b_q) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
            valid_nxt = 1'b0;
          end
        end
        ST_ERROR: begin
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign {B3, B2, B1, B0} = b_q;
  assign valid    = valid_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign wrap     = wrap_q;
  assign step_err = err_q;
  assign moves    = moves_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb/tb_gray_rx_decoder.sv - self-checking bench for gray_rx_decoder (with or without GRAY_RX_SYNC_EN)
module tb_gray_rx_decoder;

`ifdef GRAY_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int D = LAT - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_err = 1'b0;
  logic [3:0] g = 4'd0;
  logic       B0, B1, B2, B3, valid, dir, step, wrap, step_err;
  logic [7:0] moves;
  logic [3:0] b_dut;

  assign b_dut = {B3, B2, B1, B0};

  always #5 clk = ~clk;

  gray_rx_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .G0       (g[0]),
    .G1       (g[1]),
    .G2       (g[2]),
    .G3       (g[3]),
    .clr_err  (clr_err),
    .B0       (B0),
    .B1       (B1),
    .B2       (B2),
    .B3       (B3),
    .valid    (valid),
    .dir      (dir),
    .step     (step),
    .wrap     (wrap),
    .step_err (step_err),
    .moves    (moves)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int step_cnt = 0;
  int wrap_cnt = 0;

  // Reference model: mode 0 = idle, 1 = track, 2 = error.
  int m_mode, m_b, m_valid, m_dir, m_step, m_wrap, m_err, m_moves;
  int samp_q[$];

  typedef struct {
    bit         rst;
    bit         clr;
    logic [3:0] g;
    int         b;
    int         valid;
    int         dir;
    int         err;
    int         moves;
    int         steps;
    int         wraps;
  } vec_t;

  vec_t tbl[11];

  function automatic int g2b(input logic [3:0] gv);
    for (int v = 0; v < 16; v++) begin
      if (4'(v ^ (v >> 1)) == gv) return v;
    end
    return 0;
  endfunction

  function automatic logic [3:0] b2g(input int v);
    return 4'(v ^ (v >> 1));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int  nb;
    int  d;
    bit  pv;
    if (rst) begin
      m_mode = 0; m_b = 0; m_valid = 0; m_dir = 1;
      m_step = 0; m_wrap = 0; m_err = 0; m_moves = 0;
      samp_q.delete();
      return;
    end
    pv = (samp_q.size() == D);
    nb = pv ? g2b(4'(samp_q[0])) : 0;
    m_step = 0;
    m_wrap = 0;
    if (clr_err) begin
      m_mode = 0; m_err = 0; m_valid = 0; m_moves = 0;
    end else if (m_mode == 0) begin
      if (pv) begin
        m_b = nb; m_valid = 1; m_moves = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      d = (nb - m_b + 16) % 16;
      if (d == 1 || d == 15) begin
        m_wrap = (d == 1) ? (m_b == 15) : (m_b == 0);
        m_dir  = (d == 1);
        m_step = 1;
        m_b    = nb;
        if (m_moves < 255) m_moves++;
      end else if (d != 0) begin
        m_mode = 2; m_err = 1; m_valid = 0;
      end
    end
    samp_q.push_back(int'(g));
    if (samp_q.size() > D) void'(samp_q.pop_front());
  endtask

  task automatic tick();
    int act;
    int exp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    step_cnt += int'(step);
    wrap_cnt += int'(wrap);
    act = int'({b_dut, valid, dir, step, wrap, step_err, moves});
    exp = (m_b << 13) | (m_valid << 12) | (m_dir << 11) | (m_step << 10) |
          (m_wrap << 9) | (m_err << 8) | m_moves;
    check("cycle_vs_model", act, exp);
  endtask

  initial begin
    int n;
    int cur;
    int r;

    //            rst clr g        b  vld dir err mv st wr
    tbl[0]  = '{1, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 4'b0001, 1, 1, 1, 0, 1, 1, 0};
    tbl[2]  = '{0, 0, 4'b0011, 2, 1, 1, 0, 2, 1, 0};
    tbl[3]  = '{0, 0, 4'b0010, 3, 1, 1, 0, 3, 1, 0};
    tbl[4]  = '{1, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 4'b1000, 15, 1, 0, 0, 1, 1, 1};
    tbl[6]  = '{0, 0, 4'b0000, 0, 1, 1, 0, 2, 1, 1};
    tbl[7]  = '{0, 0, 4'b0001, 1, 1, 1, 0, 3, 1, 0};
    tbl[8]  = '{0, 0, 4'b0111, 1, 0, 1, 1, 3, 0, 0};
    tbl[9]  = '{0, 0, 4'b0110, 1, 0, 1, 1, 3, 0, 0};
    tbl[10] = '{0, 1, 4'b0110, 4, 1, 1, 0, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      clr_err = tbl[i].clr;
      g = tbl[i].g;
      step_cnt = 0;
      wrap_cnt = 0;
      tick();
      rst = 1'b0;
      clr_err = 1'b0;
      repeat (5) tick();
      check($sformatf("row%0d_b", i), b_dut, tbl[i].b);
      check($sformatf("row%0d_valid", i), valid, tbl[i].valid);
      check($sformatf("row%0d_dir", i), dir, tbl[i].dir);
      check($sformatf("row%0d_err", i), step_err, tbl[i].err);
      check($sformatf("row%0d_moves", i), moves, tbl[i].moves);
      check($sformatf("row%0d_steps", i), step_cnt, tbl[i].steps);
      check($sformatf("row%0d_wraps", i), wrap_cnt, tbl[i].wraps);
    end

    // Latency from input change to first B update.
    g = b2g(5);
    n = 0;
    do begin
      tick();
      n++;
    end while (b_dut != 4'd5 && n < 10);
    check("latency_edges", n, LAT);
    repeat (2) tick();

    // Illegal jump reaching the tracker on the same edge as clr_err.
    g = b2g(0);
    repeat (D) tick();
    check("pre_clr_err", step_err, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_wins_err", step_err, 0);
    check("clr_wins_valid", valid, 0);
    check("clr_wins_step", step, 0);
    tick();
    check("resync_b", b_dut, 0);
    check("resync_valid", valid, 1);

    // Saturation: 300 up-steps, one per cycle.
    rst = 1'b1;
    g = 4'd0;
    tick();
    rst = 1'b0;
    repeat (LAT + 2) tick();
    step_cnt = 0;
    wrap_cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      g = b2g(i % 16);
      tick();
    end
    repeat (LAT) tick();
    check("sat_moves", moves, 255);
    check("sat_steps", step_cnt, 300);
    check("sat_wraps", wrap_cnt, 18);
    check("sat_b", b_dut, 12);
    check("sat_dir", dir, 1);

    // Reset in the middle of a running sequence.
    for (int i = 301; i <= 310; i++) begin
      g = b2g(i % 16);
      rst = (i == 305);
      tick();
      if (i == 305) begin
        check("mid_rst_out", int'({b_dut, valid, dir, step, wrap, step_err, moves}),
              int'({4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
      end
    end
    rst = 1'b0;

    // Randomised traffic against the model.
    cur = g2b(g);
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      clr_err = 1'b0;
      rst = 1'b0;
      if (r < 60) begin
      end else if (r < 80) begin
        cur = (cur + 1) % 16;
      end else if (r < 90) begin
        cur = (cur + 15) % 16;
      end else if (r < 94) begin
        cur = int'($urandom_range(0, 15));
      end else if (r < 98) begin
        clr_err = 1'b1;
      end else begin
        rst = 1'b1;
      end
      g = b2g(cur);
      tick();
    end
    clr_err = 1'b0;
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
